// File: rtl/idu_16bit_seq_pkg.sv
// ---------------------------------------------------------------------------
// idu_16bit_seq_pkg
// Shared definitions for the 16-bit increment/decrement unit.
//   IDU_HOLD / IDU_INC / IDU_DEC : i_Op encodings (2'b11 is reserved and
//                                  decodes as hold)
//   idu_state_t                  : sequencer states IDLE -> LOW -> HIGH
// ---------------------------------------------------------------------------
package idu_16bit_seq_pkg;
   localparam logic [1:0] IDU_HOLD = 2'b00;
   localparam logic [1:0] IDU_INC  = 2'b01;
   localparam logic [1:0] IDU_DEC  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } idu_state_t;
endpackage

// File: rtl/idu_16bit_seq_if.sv
// ---------------------------------------------------------------------------
// idu_16bit_seq_if
// Request/result bundle between the sequencer (master) and the IDU (slave).
//   i_Start, i_A[15:0], i_Op[1:0]        : request, sampled in IDLE only
//   o_Busy                               : high while LOW/HIGH in progress
//   o_Low[7:0], o_Low_Valid              : low byte, one-cycle strobe
//   o_Result[15:0], o_Done, o_Wrap       : full result, strobe, wrap flag
// ---------------------------------------------------------------------------
interface idu_16bit_seq_if;
   logic        i_Start;
   logic [15:0] i_A;
   logic [1:0]  i_Op;
   logic        o_Busy;
   logic [7:0]  o_Low;
   logic        o_Low_Valid;
   logic [15:0] o_Result;
   logic        o_Done;
   logic        o_Wrap;

   modport master (
      output i_Start, i_A, i_Op,
      input  o_Busy, o_Low, o_Low_Valid, o_Result, o_Done, o_Wrap
   );

   modport slave (
      input  i_Start, i_A, i_Op,
      output o_Busy, o_Low, o_Low_Valid, o_Result, o_Done, o_Wrap
   );
endinterface

// File: rtl/idu_16bit_seq_byte_step.sv
// ---------------------------------------------------------------------------
// idu_byte_step
// Combinational 8-bit step: adds or subtracts a single carry/borrow bit.
//   i_Val[7:0] : byte operand
//   i_Cin      : carry (inc) or borrow (dec) in; 0 passes the byte through
//   i_Dec      : 1 = subtract i_Cin, 0 = add i_Cin
//   o_Val[7:0] : result modulo 2^8
//   o_Cout     : carry/borrow out of this byte
// ---------------------------------------------------------------------------
module idu_byte_step (
   input  logic [7:0] i_Val,
   input  logic       i_Cin,
   input  logic       i_Dec,
   output logic [7:0] o_Val,
   output logic       o_Cout
);
   logic [7:0] w_Cin8;

   assign w_Cin8 = {7'd0, i_Cin};
   assign o_Val  = i_Dec ? (i_Val - w_Cin8) : (i_Val + w_Cin8);
   // Only a 1-bit step, so carry/borrow out reduces to an all-ones/all-zeros test.
   assign o_Cout = i_Cin & (i_Dec ? (i_Val == 8'h00) : (i_Val == 8'hFF));
endmodule

// File: rtl/idu_16bit_seq.sv
// ---------------------------------------------------------------------------
// idu_16bit_seq
// Two-cycle 16-bit increment/decrement for register pairs. The low byte is
// stepped in LOW, the high byte in HIGH, sharing one idu_byte_step. No CPU
// flags are produced; wrap is reported on o_Wrap alongside o_Done.
//   i_Clk   : system clock, rising edge
//   i_Reset : synchronous, active-high; aborts any in-flight operation
//   bus     : idu_16bit_seq_if.slave (request in, results out)
// ---------------------------------------------------------------------------
module idu_16bit_seq
   import idu_16bit_seq_pkg::*;
(
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   idu_16bit_seq_if.slave        bus
);
   idu_state_t  r_State;
   logic [15:0] r_A;
   logic        r_Act;      // 1 = inc/dec, 0 = hold (incl. reserved op)
   logic        r_Dec;
   logic        r_Carry;    // carry/borrow from low byte into high byte
   logic        r_Busy;
   logic [7:0]  r_Low;
   logic        r_LowValid;
   logic [15:0] r_Result;
   logic        r_Done;
   logic        r_Wrap;

   logic [7:0]  w_StepIn;
   logic        w_StepCin;
   logic [7:0]  w_StepOut;
   logic        w_StepCout;

   // Time-share the byte step: low byte seeded with the op's +/-1, high
   // byte with the latched inter-byte carry.
   assign w_StepIn  = (r_State == HIGH) ? r_A[15:8] : r_A[7:0];
   assign w_StepCin = (r_State == HIGH) ? r_Carry   : r_Act;

   idu_byte_step u_step (
      .i_Val  (w_StepIn),
      .i_Cin  (w_StepCin),
      .i_Dec  (r_Dec),
      .o_Val  (w_StepOut),
      .o_Cout (w_StepCout)
   );

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_State    <= IDLE;
         r_A        <= 16'h0000;
         r_Act      <= 1'b0;
         r_Dec      <= 1'b0;
         r_Carry    <= 1'b0;
         r_Busy     <= 1'b0;
         r_Low      <= 8'h00;
         r_LowValid <= 1'b0;
         r_Result   <= 16'h0000;
         r_Done     <= 1'b0;
         r_Wrap     <= 1'b0;
      end else begin
         r_LowValid <= 1'b0;
         r_Done     <= 1'b0;
         case (r_State)
            IDLE: begin
               if (bus.i_Start) begin
                  r_A <= bus.i_A;
                  case (bus.i_Op)
                     IDU_INC: begin r_Act <= 1'b1; r_Dec <= 1'b0; end
                     IDU_DEC: begin r_Act <= 1'b1; r_Dec <= 1'b1; end
                     default: begin r_Act <= 1'b0; r_Dec <= 1'b0; end
                  endcase
                  r_Busy  <= 1'b1;
                  r_State <= LOW;
               end
            end
            LOW: begin
               r_Low      <= w_StepOut;
               r_Carry    <= w_StepCout;
               r_LowValid <= 1'b1;
               r_State    <= HIGH;
            end
            HIGH: begin
               r_Result <= {w_StepOut, r_Low};
               r_Wrap   <= w_StepCout;
               r_Done   <= 1'b1;
               r_Busy   <= 1'b0;
               r_State  <= IDLE;
            end
            default: r_State <= IDLE;
         endcase
      end
   end

   assign bus.o_Busy      = r_Busy;
   assign bus.o_Low       = r_Low;
   assign bus.o_Low_Valid = r_LowValid;
   assign bus.o_Result    = r_Result;
   assign bus.o_Done      = r_Done;
   assign bus.o_Wrap      = r_Wrap;
endmodule

// File: doc/idu_16bit_seq.md
# idu_16bit_seq

Sequential 16-bit increment/decrement unit for register pairs (BC, DE, HL, SP, PC) serving INC rr, DEC rr, LD (HL+)/(HL-) and PC advance. It walks the value through an 8-bit step datapath in two cycles, low byte then high byte, with carry/borrow propagated between them, and never touches the CPU flags. The sequencer owns it and writes results back to the register file.

## Interface
- No parameters; width fixed at 16 bits, split as two 8-bit halves.
- i_Clk  input  1  single system clock, rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Start  input  1  request; accepted only in IDLE.
- i_A  input  16  operand; captured on accept.
- i_Op  input  2  00 hold (pass-through), 01 increment, 10 decrement, 11 reserved (treated as hold).
- o_Busy  output  1  high in LOW and HIGH states.
- o_Low  output  8  low result byte.
- o_Low_Valid  output  1  one-cycle pulse when o_Low is updated.
- o_Result  output  16  full result.
- o_Done  output  1  one-cycle pulse when o_Result is updated.
- o_Wrap  output  1  set when result wrapped (FFFF+1 or 0000-1); valid with o_Done.

## Operation
- States: IDLE, LOW, HIGH.
- IDLE: i_Start=1 -> capture i_A and i_Op, go to LOW. i_Start=0 -> stay.
- LOW: low = A[7:0] + 1 (inc), A[7:0] - 1 (dec), A[7:0] (hold). Latch inter-byte carry: inc carry = (A[7:0]==FF); dec borrow = (A[7:0]==00); hold 0. Register o_Low, pulse o_Low_Valid. Go to HIGH.
- HIGH: high = A[15:8] ± latched carry/borrow. Register o_Result = {high, low}. Set o_Wrap = carry out of the high byte. Pulse o_Done. Go to IDLE.
- All arithmetic is modulo 2^8 per byte. Overflow is reported only via o_Wrap; no flag outputs.
- i_Start while o_Busy=1 is ignored. No queueing and no change to the captured operand.
- i_Op=11 behaves exactly as hold, with o_Wrap=0.
- Reset, including mid-operation: state returns to IDLE and the in-flight operation is discarded. o_Busy, o_Low_Valid, o_Done and o_Wrap go to 0. o_Low and o_Result go to 0x00 / 0x0000.
- o_Low, o_Result and o_Wrap hold their values until overwritten by the next operation.

## Timing
- Cycle 0: i_Start sampled high in IDLE.
- Cycle 1: state LOW, o_Busy=1.
- Cycle 2: state HIGH, o_Busy=1; o_Low and o_Low_Valid visible.
- Cycle 3: state IDLE, o_Busy=0; o_Result, o_Wrap and o_Done visible.
- Latency from accept to o_Done is 3 cycles; throughput is one operation per 3 cycles.
- A new i_Start may be accepted in the same cycle o_Done is high (back-to-back operation).
- The write-back stage may consume o_Low one cycle before o_Result, which allows L and H to be written in consecutive cycles.

## Structure
- Shared CPU package holds:
  - IDU op encodings (IDU_HOLD, IDU_INC, IDU_DEC);
  - state enum (IDLE, LOW, HIGH).
- One sub-module, idu_byte_step. It is combinational: 8-bit value, carry-in, decrement select in; 8-bit value and carry/borrow-out out. It is instantiated once and time-shared across the LOW and HIGH states.
- The top level contains the FSM, operand and carry registers, and output registers.

## Test plan
- Increment across the byte boundary: i_A=0x00FF, inc. o_Low_Valid with o_Low=0x00 at cycle 2; o_Done with o_Result=0x0100, o_Wrap=0 at cycle 3.
- Wrap in both directions: 0xFFFF inc -> 0x0000, o_Wrap=1; 0x0000 dec -> 0xFFFF, o_Wrap=1; 0x0100 dec -> 0x00FF, o_Wrap=0.
- Hold and reserved op: 0x1234 with i_Op=00, then with i_Op=11. Both give 0x1234, o_Wrap=0, same 3-cycle latency.
- Busy and back-to-back:
  - i_Start held high for 6 cycles with 0x0001 inc then 0x0002 dec. Exactly two o_Done pulses, at cycles 3 and 6, with results 0x0002 and 0x0001.
  - Inputs changed mid-operation do not alter the result.
- Reset mid-operation: assert i_Reset during HIGH. Next cycle is IDLE, o_Busy=0, o_Done=0, o_Result=0x0000, and no o_Done pulse follows.
- Random regression: 1000 random operand/op pairs checked against a 16-bit modulo reference model, including o_Wrap and the o_Low/o_Done pulse spacing.
